alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
// Round-robin arbiter and sequencer sharing one combinational 4-bit multi-mode ALU
// (Mode 00 add, 01 mul, 10 A>>2, 11 all-ones; 8-bit result) between N_REQ requesters.
// Grants one request at a time, drives registered operands to the ALU, captures its
// result and returns it with the requester ID over a valid/ready response channel.
// Sits between requester blocks and the single ALU instance; counts completed ops.
// PARAMETERS
// N_REQ  2  number of requesters (>=2); IDW = $clog2(N_REQ)
// DW     4  operand width (matches ALU A/B)
// RW     8  result width (matches ALU Y)
// CW     16 completed-operation counter width
// PORTS
// clk        in   1         single clock, rising edge
// rst_n      in   1         reset; one clock; reset is asynchronous and active-low
// req_valid  in   N_REQ     per-requester request valid
// req_ready  out  N_REQ     per-requester accept (one-hot or zero)
// req_a      in   N_REQ*DW  packed operand A, requester i at [i*DW +: DW]
// req_b      in   N_REQ*DW  packed operand B, same packing
// req_mode   in   N_REQ*2   packed Mode, requester i at [i*2 +: 2]
// alu_a      out  DW        registered operand A to ALU
// alu_b      out  DW        registered operand B to ALU
// alu_mode   out  2         registered Mode to ALU
// alu_y      in   RW        ALU combinational result
// rsp_valid  out  1         response valid
// rsp_ready  in   1         response consumer ready
// rsp_y      out  RW        captured result
// rsp_id     out  IDW       index of requester that issued the op
// busy       out  1         high whenever state != IDLE
// op_count   out  CW        completed responses, wraps modulo 2^CW
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE; req_ready=0; alu_a/alu_b/alu_mode=0; rsp_valid=0;
//   rsp_y=0; rsp_id=0; busy=0; op_count=0; RR pointer=N_REQ-1 (requester 0 wins first).
// - FSM IDLE -> EXEC -> RESP -> IDLE.
// - IDLE: if any req_valid, winner g = first valid index searching ptr+1, ptr+2, ...
//   modulo N_REQ; req_ready[g]=1 combinationally (only in IDLE, only for g). At edge:
//   latch req_a/b/mode[g] into alu_a/b/mode, store g as rsp_id and ptr, go EXEC.
//   No valid: stay IDLE, req_ready=0, ptr unchanged.
// - EXEC: one cycle, ALU settles on registered operands; at edge capture alu_y into
//   rsp_y, set rsp_valid=1, go RESP.
// - RESP: rsp_valid=1, rsp_y/rsp_id stable. On rsp_valid&&rsp_ready edge: rsp_valid=0,
//   op_count+=1 (wraps 2^CW-1 -> 0), go IDLE. rsp_ready low: hold indefinitely.
// - Latency: accept edge E0 -> rsp_valid high after E0+1. Max throughput one op per
//   3 cycles with rsp_ready tied high. No new grant while EXEC/RESP (req_ready all 0).
// - Requesters hold valid and operands stable until ready; arbiter samples only at grant,
//   so later changes/withdrawal do not affect an issued op.
// - alu_a/b/mode hold last granted values between ops (no return to 0).
// - Arbiter transparent to arithmetic: rsp_y equals ALU output bit-for-bit, no truncation.
// - Reset mid-operation (EXEC or RESP): pending op and response discarded, all as reset.
// - Single requester continuously valid: re-granted every op (RR skips idle requesters).
// TESTING (bench instantiates the team's 4-bit multi-mode ALU as the shared datapath)
// 1 Req0 A=3 B=5 Mode=00, rsp_ready=1 -> req_ready[0] in IDLE, rsp_valid 2 cycles later,
//   rsp_y=8'h08, rsp_id=0, op_count=1; then Mode=01 A=15 B=15 -> 8'hE1; Mode=10 A=12 ->
//   8'h03; Mode=11 -> 8'hFF.
// 2 Req0 and req1 valid continuously, 8 ops -> rsp_id sequence 0,1,0,1,0,1,0,1; never two
//   req_ready bits high.
// 3 rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_y, rsp_id stable, req_ready=0,
//   busy=1; release -> one handshake, op_count +1 only.
// 4 rst_n low during EXEC -> all outputs zero immediately, no response; after release
//   req1 only valid -> granted, rsp_id=1.
// 5 Force op_count=16'hFFFF (or run 65536 ops) -> next handshake gives op_count=0.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin arbiter/sequencer sharing one combinational multi-mode ALU
// Grants one requester at a time, registers its operands to the ALU and returns the result with its ID.
module alu_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int DW    = 4,
  parameter int RW    = 8,
  parameter int CW    = 16,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  input  logic [N_REQ*2-1:0]  req_mode,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [1:0]          alu_mode,
  input  logic [RW-1:0]       alu_y,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [RW-1:0]       rsp_y,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy,
  output logic [CW-1:0]       op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_id;
  logic           grant_found;

  logic [DW-1:0]  a_arr    [N_REQ];
  logic [DW-1:0]  b_arr    [N_REQ];
  logic [1:0]     mode_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i]    = req_a[i*DW +: DW];
    assign b_arr[i]    = req_b[i*DW +: DW];
    assign mode_arr[i] = req_mode[i*2 +: 2];
  end

  // First loop finds the lowest valid index (wrap-around case); the second overrides it
  // with the lowest valid index above the pointer, giving ptr+1, ptr+2, ... order.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i > int'(ptr))) begin
        grant_id = IDW'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= IDW'(N_REQ - 1);
      alu_a     <= '0;
      alu_b     <= '0;
      alu_mode  <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            alu_a    <= a_arr[grant_id];
            alu_b    <= b_arr[grant_id];
            alu_mode <= mode_arr[grant_id];
            rsp_id   <= grant_id;
            ptr      <= grant_id;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_y     <= alu_y;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - self-checking bench for alu_rr_arbiter with a behavioural RR/ALU model
module tb_alu_rr_arbiter;
  localparam int N   = 2;
  localparam int DW  = 4;
  localparam int RW  = 8;
  localparam int CW  = 16;
  localparam int IDW = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready, req_ready_w;
  logic [N*DW-1:0] req_a, req_b;
  logic [N*2-1:0]  req_mode;
  logic [DW-1:0]   alu_a, alu_b, alu_a_w, alu_b_w;
  logic [1:0]      alu_mode, alu_mode_w;
  logic [RW-1:0]   alu_y, alu_y_w, rsp_y, rsp_y_w;
  logic            rsp_valid, rsp_valid_w, rsp_ready, busy, busy_w;
  logic [IDW-1:0]  rsp_id, rsp_id_w;
  logic [CW-1:0]   op_count;
  logic [3:0]      op_count_w;

  int total = 0;
  int bad   = 0;
  int m_last;
  int m_count;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(logic [3:0] a, logic [3:0] b, logic [1:0] m);
    case (m)
      2'b00:   return 8'(a) + 8'(b);
      2'b01:   return 8'(a) * 8'(b);
      2'b10:   return 8'(a >> 2);
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int model_winner(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  assign alu_y   = alu_fn(alu_a, alu_b, alu_mode);
  assign alu_y_w = alu_fn(alu_a_w, alu_b_w, alu_mode_w);

  alu_rr_arbiter #(.N_REQ(N), .DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id),
    .busy(busy), .op_count(op_count)
  );

  // Narrow-counter copy on the same inputs so the counter wrap is reached quickly.
  alu_rr_arbiter #(.N_REQ(N), .DW(DW), .RW(RW), .CW(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
    .alu_a(alu_a_w), .alu_b(alu_b_w), .alu_mode(alu_mode_w), .alu_y(alu_y_w),
    .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready), .rsp_y(rsp_y_w), .rsp_id(rsp_id_w),
    .busy(busy_w), .op_count(op_count_w)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req_a = 8'h35; req_b = 8'h35; req_mode = 4'h5;
    #2;
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    total++;
    if ({alu_a, alu_b, alu_mode} !== 10'd0) begin bad++; $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_mode}); end
    total++;
    if ({rsp_valid, rsp_y, rsp_id, busy} !== 11'd0) begin bad++; $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_y, rsp_id, busy}); end
    total++;
    if (op_count !== 16'd0 || op_count_w !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d/%0d exp=0", op_count, op_count_w); end
    req_valid = 2'b00;
    cyc();
    rst_n = 1'b1;
    m_last = N - 1; m_count = 0;
    cyc();
  endtask

  task automatic test_modes();
    logic [3:0] av [4] = '{4'd3, 4'd15, 4'd12, 4'd0};
    logic [3:0] bv [4] = '{4'd5, 4'd15, 4'd7, 4'd0};
    logic [1:0] mv [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [7:0] yv [4] = '{8'h08, 8'hE1, 8'h03, 8'hFF};
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b01; req_a = {4'h0, av[i]}; req_b = {4'h0, bv[i]}; req_mode = {2'b00, mv[i]};
      #1;
      total++;
      if (req_ready !== 2'b01) begin bad++; $display("FAIL modes_ready i=%0d got=%b exp=01", i, req_ready); end
      cyc();
      req_valid = 2'b00; req_a = 8'hFF; req_b = 8'hFF; req_mode = 4'hF;
      total++;
      if (!(busy === 1'b1 && rsp_valid === 1'b0 && alu_a === av[i] && alu_b === bv[i] && alu_mode === mv[i]))
        begin bad++; $display("FAIL modes_exec i=%0d busy=%b rv=%b a=%h b=%h m=%b", i, busy, rsp_valid, alu_a, alu_b, alu_mode); end
      cyc();
      total++;
      if (!(rsp_valid === 1'b1 && rsp_y === yv[i] && rsp_id === 1'b0))
        begin bad++; $display("FAIL modes_rsp i=%0d rv=%b y=%h id=%0d exp y=%h id=0", i, rsp_valid, rsp_y, rsp_id, yv[i]); end
      cyc();
      m_count++; m_last = 0;
      total++;
      if (!(rsp_valid === 1'b0 && busy === 1'b0 && op_count === CW'(m_count)))
        begin bad++; $display("FAIL modes_done i=%0d rv=%b count=%0d exp=%0d", i, rsp_valid, op_count, m_count); end
    end
  endtask

  task automatic test_round_robin();
    int got = 0;
    int cycles = 0;
    rst_n = 1'b0; #1; m_last = N - 1; m_count = 0;
    cyc(); rst_n = 1'b1;
    req_valid = 2'b11; rsp_ready = 1'b1;
    req_a = 8'($urandom); req_b = 8'($urandom); req_mode = 4'($urandom);
    #1;
    while (got < 8 && cycles < 40) begin
      total++;
      if ($countones(req_ready) > 1) begin bad++; $display("FAIL rr_onehot got=%b exp=at most one bit", req_ready); end
      if (rsp_valid === 1'b1) begin
        total++;
        if (rsp_id !== IDW'(got % 2) || rsp_y !== alu_fn(req_a[got%2*DW +: DW], req_b[got%2*DW +: DW], req_mode[got%2*2 +: 2]))
          begin bad++; $display("FAIL rr_seq op=%0d id=%0d exp=%0d y=%h", got, rsp_id, got % 2, rsp_y); end
        got++;
      end
      cyc(); cycles++;
    end
    total++;
    if (got != 8) begin bad++; $display("FAIL rr_timeout got=%0d exp=8 responses", got); end
    m_count = got; m_last = 1;
    req_valid = 2'b00;
    cyc();
    total++;
    if (op_count !== CW'(m_count)) begin bad++; $display("FAIL rr_count got=%0d exp=%0d", op_count, m_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] y0;
    logic [IDW-1:0] id0;
    int w;
    req_valid = 2'b11; rsp_ready = 1'b0;
    req_a = 8'($urandom); req_b = 8'($urandom); req_mode = 4'($urandom);
    w = model_winner(req_valid, m_last);
    cyc(); cyc();
    m_last = w;
    y0 = rsp_y; id0 = rsp_id;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== IDW'(w) || rsp_y !== alu_fn(req_a[w*DW +: DW], req_b[w*DW +: DW], req_mode[w*2 +: 2]))
      begin bad++; $display("FAIL bp_first rv=%b id=%0d exp=%0d y=%h", rsp_valid, rsp_id, w, rsp_y); end
    for (int s = 0; s < 5; s++) begin
      cyc();
      total++;
      if (!(rsp_valid === 1'b1 && rsp_y === y0 && rsp_id === id0 && req_ready === 2'b00 && busy === 1'b1 && op_count === CW'(m_count)))
        begin bad++; $display("FAIL bp_hold s=%0d rv=%b y=%h id=%0d rdy=%b busy=%b cnt=%0d", s, rsp_valid, rsp_y, rsp_id, req_ready, busy, op_count); end
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    cyc(); m_count++;
    cyc();
    total++;
    if (rsp_valid !== 1'b0 || op_count !== CW'(m_count)) begin bad++; $display("FAIL bp_release rv=%b cnt=%0d exp=%0d", rsp_valid, op_count, m_count); end
  endtask

  task automatic test_reset_exec();
    req_valid = 2'b01; req_a = 8'h47; req_b = 8'h29; req_mode = 4'h5;
    cyc();
    rst_n = 1'b0; #1;
    m_last = N - 1; m_count = 0;
    total++;
    if ({req_ready, alu_a, alu_b, alu_mode, rsp_valid, rsp_y, rsp_id, busy} !== 23'd0 || op_count !== 16'd0)
      begin bad++; $display("FAIL rst_exec outs=%h cnt=%0d exp=0", {req_ready, alu_a, alu_b, alu_mode, rsp_valid, rsp_y, rsp_id, busy}, op_count); end
    cyc();
    rst_n = 1'b1; req_valid = 2'b10; req_a = 8'h9C; req_b = 8'hE3; req_mode = 4'h7;
    #1;
    total++;
    if (req_ready !== 2'b10 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_regrant rdy=%b rv=%b exp=10/0", req_ready, rsp_valid); end
    cyc(); req_valid = 2'b00;
    cyc();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_y !== alu_fn(4'h9, 4'hE, 2'b01))
      begin bad++; $display("FAIL rst_rsp rv=%b id=%0d y=%h exp id=1 y=%h", rsp_valid, rsp_id, rsp_y, alu_fn(4'h9, 4'hE, 2'b01)); end
    cyc(); m_count = 1; m_last = 1;
    total++;
    if (op_count !== 16'd1) begin bad++; $display("FAIL rst_count got=%0d exp=1", op_count); end
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    logic [7:0]   exp_y;
    int w, stall;
    rsp_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      mask = N'($urandom_range(0, 3));
      req_valid = mask; req_a = 8'($urandom); req_b = 8'($urandom); req_mode = 4'($urandom);
      #1;
      w = model_winner(mask, m_last);
      total++;
      if (req_ready !== ((w < 0) ? 2'b00 : 2'(1 << w))) begin bad++; $display("FAIL rnd_grant n=%0d got=%b w=%0d", n, req_ready, w); end
      if (w < 0) begin
        cyc();
        continue;
      end
      exp_y = alu_fn(req_a[w*DW +: DW], req_b[w*DW +: DW], req_mode[w*2 +: 2]);
      stall = $urandom_range(0, 2);
      cyc();
      m_last = w;
      req_valid = N'($urandom); req_a = 8'($urandom); req_b = 8'($urandom); req_mode = 4'($urandom);
      cyc();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(w) || rsp_y !== exp_y)
        begin bad++; $display("FAIL rnd_rsp n=%0d rv=%b id=%0d y=%h exp id=%0d y=%h", n, rsp_valid, rsp_id, rsp_y, w, exp_y); end
      if (stall > 0) begin
        rsp_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          cyc();
          total++;
          if (rsp_valid !== 1'b1 || rsp_y !== exp_y || req_ready !== 2'b00)
            begin bad++; $display("FAIL rnd_stall n=%0d rv=%b y=%h rdy=%b", n, rsp_valid, rsp_y, req_ready); end
        end
        rsp_ready = 1'b1;
      end
      cyc();
      m_count++;
      total++;
      if (rsp_valid !== 1'b0 || op_count !== CW'(m_count) || op_count_w !== 4'(m_count))
        begin bad++; $display("FAIL rnd_count n=%0d got=%0d/%0d exp=%0d", n, op_count, op_count_w, m_count); end
    end
    req_valid = 2'b00;
    cyc();
  endtask

  task automatic test_wrap();
    rsp_ready = 1'b1;
    for (int guard = 0; guard < 20 && (m_count % 16) != 15; guard++) begin
      req_valid = 2'b01; req_a = 8'h12; req_b = 8'h34; req_mode = 4'h0;
      cyc(); req_valid = 2'b00;
      cyc(); cyc();
      m_count++; m_last = 0;
    end
    total++;
    if (op_count_w !== 4'd15) begin bad++; $display("FAIL wrap_pre got=%0d exp=15", op_count_w); end
    req_valid = 2'b01;
    cyc(); req_valid = 2'b00;
    cyc(); cyc();
    m_count++;
    total++;
    if (op_count_w !== 4'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", op_count_w); end
    total++;
    if (op_count !== CW'(m_count)) begin bad++; $display("FAIL wrap_wide got=%0d exp=%0d", op_count, m_count); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
